// File: rtl/bq_pkg.sv
// Shared constants and types for the bounded-queue ingress stage.
package bq_pkg;

    localparam int BQ_DATA_W = 8;
    localparam int BQ_DEPTH  = 11;
    localparam int BQ_CNT_W  = 4;
    localparam int BQ_DROP_W = 8;

    typedef logic [BQ_DATA_W-1:0] bq_sample_t;
    typedef logic [BQ_CNT_W-1:0]  bq_idx_t;

endpackage

// File: rtl/bq_wrap_ptr.sv
// Queue pointer that steps by one on inc and returns to 0 after DEPTH-1
// (not a power-of-two wrap).
module bq_wrap_ptr
    import bq_pkg::*;
#(
    parameter int DEPTH = BQ_DEPTH,
    parameter int CNT_W = BQ_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] ptr
);

    logic [CNT_W-1:0] ptr_q;
    logic [CNT_W-1:0] ptr_d;

    // Next pointer value with explicit wrap at the last storage index.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            if (ptr_q == CNT_W'(DEPTH - 1)) begin
                ptr_d = {CNT_W{1'b0}};
            end else begin
                ptr_d = ptr_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= {CNT_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/bounded_queue_ingress.sv
// Bounded first-word-fall-through FIFO with valid/ready on both sides,
// occupancy, high-water mark and a saturating refused-sample counter.
module bounded_queue_ingress
    import bq_pkg::*;
#(
    parameter int DATA_W = BQ_DATA_W,
    parameter int DEPTH  = BQ_DEPTH,
    parameter int CNT_W  = BQ_CNT_W,
    parameter int DROP_W = BQ_DROP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  high_water,
    output logic [DROP_W-1:0] drop_cnt
);

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    logic [CNT_W-1:0]  wr_ptr_s;
    logic [CNT_W-1:0]  rd_ptr_s;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [CNT_W-1:0]  hw_q;
    logic [CNT_W-1:0]  hw_d;
    logic [DROP_W-1:0] drop_q;
    logic [DROP_W-1:0] drop_d;
    logic              push_s;
    logic              pop_s;

    // in_ready looks only at registered occupancy, never at out_ready.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != {CNT_W{1'b0}});
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;

    assign out_data  = out_valid ? mem_q[rd_ptr_s] : {DATA_W{1'b0}};

    bq_wrap_ptr #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_s),
        .ptr (wr_ptr_s)
    );

    bq_wrap_ptr #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_s),
        .ptr (rd_ptr_s)
    );

    // Occupancy next state from the push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Peak tracks the post-update occupancy every cycle.
    always_comb begin
        hw_d = hw_q;
        if (count_d > hw_q) begin
            hw_d = count_d;
        end else begin
            hw_d = hw_q;
        end
    end

    // A sample offered while full is refused and counted, saturating at all-ones.
    always_comb begin
        drop_d = drop_q;
        if (in_valid && !in_ready && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + {{(DROP_W-1){1'b0}}, 1'b1};
        end else begin
            drop_d = drop_q;
        end
    end

    // Status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= {CNT_W{1'b0}};
            hw_q    <= {CNT_W{1'b0}};
            drop_q  <= {DROP_W{1'b0}};
        end else begin
            count_q <= count_d;
            hw_q    <= hw_d;
            drop_q  <= drop_d;
        end
    end

    // Sample storage is deliberately not cleared; writes are blocked during reset.
    always_ff @(posedge clk) begin
        if (rst && push_s) begin
            mem_q[wr_ptr_s] <= in_data;
        end
    end

    assign count      = count_q;
    assign high_water = hw_q;
    assign drop_cnt   = drop_q;

endmodule
